// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request at a time, captures the
// returned word into the IF/ID register and steers the PC load value.
//
// state | meaning
// IDLE  | no request outstanding; starts a fetch when IF/ID can take it
// REQ   | imem_req asserted, address held until imem_ack
// WAIT  | request accepted, waiting for imem_rvalid
module fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int PC_STEP = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic [ADDR_W-1:0]  pc_load_value,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_stall,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state, state_nxt;
    logic                kill, kill_nxt;
    logic [ADDR_W-1:0]   req_addr, req_addr_nxt;
    logic                capture;
    logic                out_free;
    logic [ADDR_W-1:0]   seq_addr;

    assign out_free = !if_valid || !id_stall;
    assign seq_addr = req_addr + ADDR_W'(PC_STEP);

    always_comb begin
        state_nxt    = state;
        kill_nxt     = kill;
        req_addr_nxt = req_addr;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                // a redirect here just lets the PC take the target first
                if (out_free && !redirect_valid) begin
                    state_nxt    = REQ;
                    req_addr_nxt = pc_addr;
                end
            end
            REQ: begin
                if (redirect_valid) kill_nxt = 1'b1;
                if (imem_ack) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                    kill_nxt  = 1'b0;
                    capture   = !kill && !redirect_valid;
                end else if (redirect_valid) begin
                    kill_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_load_value = pc_addr;
        if (redirect_valid)
            pc_load_value = redirect_addr;
        else if (state == WAIT && imem_rvalid && !kill)
            pc_load_value = seq_addr;
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = req_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            kill     <= 1'b0;
            req_addr <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            state    <= state_nxt;
            kill     <= kill_nxt;
            req_addr <= req_addr_nxt;
            // capture has priority over both flush and consume
            if (capture) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= req_addr;
            end else if (redirect_valid || !id_stall) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of sequential fetches plus stall,
// redirect, back-pressure and async-reset sequences.
module tb_fetch_unit;

    localparam logic [15:0] PC_RST = 16'h0300;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_load_value;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .pc_addr        (pc),
        .pc_load_value  (pc_load_value),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clock = ~clock;

    // PC register owned by the bench, loaded from the DUT every cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc <= PC_RST;
        else        pc <= pc_load_value;
    end

    typedef struct {
        logic        set;
        logic [15:0] pc;
        int          ack_dly;
        int          lat;
        logic [15:0] data;
        logic [15:0] addr;
        logic [15:0] nxt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input logic [15:0] a);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!imem_req) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_timeout: got no imem_req expected request at %h", a);
        end else begin
            chk("req_addr", 32'(imem_addr), 32'(a));
        end
    endtask

    task automatic fetch(input logic [15:0] a, input int ack_dly, input int lat,
                         input logic [15:0] d, input logic [15:0] nxt);
        wait_req(a);
        repeat (ack_dly) begin
            @(negedge clock);
            chk("req_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, a});
        end
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        repeat (lat - 1) @(negedge clock);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        #1 chk("pc_next", 32'(pc_load_value), 32'(nxt));
        @(negedge clock);
        imem_rvalid = 1'b0;
        chk("if_valid", 32'(if_valid), 32'd1);
        chk("if_instr", 32'(if_instr), 32'(d));
        chk("if_pc", 32'(if_pc), 32'(a));
    endtask

    initial begin
        logic [15:0] held;
        vecs[0] = '{1'b1, 16'h0010, 0, 2, 16'h1234, 16'h0010, 16'h0011};
        vecs[1] = '{1'b0, 16'h0000, 1, 1, 16'hBEEF, 16'h0011, 16'h0012};
        vecs[2] = '{1'b0, 16'h0000, 3, 4, 16'h0F0F, 16'h0012, 16'h0013};
        vecs[3] = '{1'b1, 16'hFFFF, 0, 1, 16'hA5A5, 16'hFFFF, 16'h0000};
        vecs[4] = '{1'b0, 16'h0000, 0, 3, 16'h5A5A, 16'h0000, 16'h0001};

        repeat (3) @(negedge clock);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", 32'(if_instr), 32'd0);
        chk("rst_pc", 32'(if_pc), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].set) begin
                redirect_valid = 1'b1;
                redirect_addr  = vecs[i].pc;
                #1 chk("redir_idle", 32'(pc_load_value), 32'(vecs[i].pc));
                @(negedge clock);
                redirect_valid = 1'b0;
            end
            fetch(vecs[i].addr, vecs[i].ack_dly, vecs[i].lat, vecs[i].data, vecs[i].nxt);
        end

        // stall with IF/ID full
        id_stall = 1'b1;
        held = if_instr;
        repeat (5) begin
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_instr", 32'(if_instr), 32'(held));
            #1 chk("stall_pc", 32'(pc_load_value), 32'h0001);
            @(negedge clock);
        end
        id_stall = 1'b0;
        fetch(16'h0001, 0, 1, 16'h7777, 16'h0002);

        // redirect while waiting for data
        wait_req(16'h0002);
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0200;
        #1 chk("redir_wait_pc", 32'(pc_load_value), 32'h0200);
        @(negedge clock);
        redirect_valid = 1'b0;
        chk("redir_flush", 32'(if_valid), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        #1 chk("kill_hold_pc", 32'(pc_load_value), 32'h0200);
        @(negedge clock);
        imem_rvalid = 1'b0;
        chk("kill_drop", 32'(if_valid), 32'd0);
        fetch(16'h0200, 0, 2, 16'h1111, 16'h0201);

        // ack back-pressure with redirect in the second cycle
        wait_req(16'h0201);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0201});
            redirect_valid = (i == 1);
            redirect_addr  = 16'h0400;
            @(negedge clock);
        end
        redirect_valid = 1'b0;
        imem_ack = 1'b1;
        chk("bp_hold_ack", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0201});
        @(negedge clock);
        imem_ack = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hBAD0;
        #1 chk("bp_kill_pc", 32'(pc_load_value), 32'h0400);
        @(negedge clock);
        imem_rvalid = 1'b0;
        chk("bp_drop", 32'(if_valid), 32'd0);
        fetch(16'h0400, 0, 1, 16'h2222, 16'h0401);

        // asynchronous reset while waiting
        wait_req(16'h0401);
        imem_ack = 1'b1;
        @(negedge clock);
        imem_ack = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_instr", 32'(if_instr), 32'd0);
        @(negedge clock);
        imem_rvalid = 1'b1;
        imem_rdata  = 16'h9999;
        #2 reset = 1'b1;
        @(negedge clock);
        imem_rvalid = 1'b0;
        chk("late_rvalid", 32'(if_valid), 32'd0);
        fetch(PC_RST, 0, 1, 16'h3333, 16'h0301);
        @(negedge clock);
        chk("consume", 32'(if_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
